// File: rtl/mem_resp_align_if.sv
// Shared request-field types and the handshake bundle for mem_resp_align.
//   memfnt::mem_func_t : ld / st / nm (nm = no memory access)
//   memszt::mem_size_t : b / h / w access size
//   ldextt::load_ext_t : s (sign) / z (zero) load extension
// mem_resp_align_if groups the request, memory-response and writeback
// signals; slave is the tracker side, master the issuing/consuming side.
//   req_*    : request issue handshake and the fields to record
//   mem_*    : in-order response pulse and raw read word
//   wb_*     : valid/ready load writeback
//   st_done  : store retire pulse
//   err_unexp: sticky flag for a response with nothing pending
package memfnt;
  typedef enum logic [1:0] {ld = 2'd0, st = 2'd1, nm = 2'd2} mem_func_t;
endpackage

package memszt;
  typedef enum logic [1:0] {b = 2'd0, h = 2'd1, w = 2'd2} mem_size_t;
endpackage

package ldextt;
  typedef enum logic {s = 1'b0, z = 1'b1} load_ext_t;
endpackage

interface mem_resp_align_if #(parameter int TAG_W = 6) ();
  logic              req_valid;
  logic              req_ready;
  memfnt::mem_func_t req_memfn;
  memszt::mem_size_t req_memsz;
  ldextt::load_ext_t req_ldext;
  logic [1:0]        req_addr_lo;
  logic [TAG_W-1:0]  req_tag;
  logic              mem_resp;
  logic [31:0]       mem_rdata;
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_data;
  logic [TAG_W-1:0]  wb_tag;
  logic              st_done;
  logic              err_unexp;

  modport slave (
    input  req_valid, req_memfn, req_memsz, req_ldext, req_addr_lo, req_tag,
    input  mem_resp, mem_rdata, wb_ready,
    output req_ready, wb_valid, wb_data, wb_tag, st_done, err_unexp
  );

  modport master (
    output req_valid, req_memfn, req_memsz, req_ldext, req_addr_lo, req_tag,
    output mem_resp, mem_rdata, wb_ready,
    input  req_ready, wb_valid, wb_data, wb_tag, st_done, err_unexp
  );
endinterface

// File: rtl/mem_resp_align.sv
// mem_resp_align: in-order response tracker for the data-memory port.
// Records every issued ld/st, aligns and extends load data when the
// in-order response arrives, retires stores with a st_done pulse and
// hands load results to the writeback arbiter over valid/ready.
// Ports: clk, rst_n (async active low), bus (mem_resp_align_if.slave).
// Parameters: DEPTH (tracked entries, power of two >= 2), TAG_W.
// Build option: MEM_RESP_ALIGN_BYPASS_EN -- a response that completes the
// head entry is presented in the same cycle instead of one cycle later.

// Load data aligner: picks the addressed byte/half and extends it.
module mem_resp_align_ext (
  input  memszt::mem_size_t sz,
  input  ldextt::load_ext_t ext,
  input  logic [1:0]        lo,
  input  logic [31:0]       rdata,
  output logic [31:0]       data
);
  logic [7:0]  byt;
  logic [15:0] hw;
  logic        sx;

  always_comb begin
    byt  = rdata[7:0];
    case (lo)
      2'd1:    byt = rdata[15:8];
      2'd2:    byt = rdata[23:16];
      2'd3:    byt = rdata[31:24];
      default: byt = rdata[7:0];
    endcase
    // halfword select only looks at the upper address bit
    hw   = lo[1] ? rdata[31:16] : rdata[15:0];
    sx   = (ext == ldextt::s);
    data = rdata;
    case (sz)
      memszt::b: data = {{24{sx & byt[7]}}, byt};
      memszt::h: data = {{16{sx & hw[15]}}, hw};
      default:   data = rdata;
    endcase
  end
endmodule

module mem_resp_align #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input logic             clk,
  input logic             rst_n,
  mem_resp_align_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    memfnt::mem_func_t fn;
    memszt::mem_size_t sz;
    ldextt::load_ext_t ext;
    logic [1:0]        lo;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  ent_t        ent_q [DEPTH];
  logic [31:0] dat_q [DEPTH];
  logic [DEPTH-1:0] done_q;

  // Pointers carry one extra wrap bit so rsp==wr unambiguously means
  // "nothing pending" even when all DEPTH entries await a response.
  logic [PW:0] wr_q, rsp_q, rd_q;
  logic [PW:0] cnt_q;
  logic        err_q;

  logic [PW-1:0] wr_i, rsp_i, rd_i;
  logic          rdy, push, pending, rsp_hit, head_done, byp, pop, byp_pop;
  logic [31:0]   aligned;

  assign wr_i  = wr_q[PW-1:0];
  assign rsp_i = rsp_q[PW-1:0];
  assign rd_i  = rd_q[PW-1:0];

  // Space is judged on the registered count only; a same-cycle pop does
  // not make room for a push.
  assign rdy     = (cnt_q < (PW+1)'(DEPTH));
  assign push    = bus.req_valid && rdy && (bus.req_memfn != memfnt::nm);
  assign pending = (rsp_q != wr_q);
  assign rsp_hit = bus.mem_resp && pending;
  // Completed entries live in [rd, rsp); an outstanding head is not done.
  assign head_done = (cnt_q != '0) && done_q[rd_i];

  mem_resp_align_ext u_ext (
    .sz    (ent_q[rsp_i].sz),
    .ext   (ent_q[rsp_i].ext),
    .lo    (ent_q[rsp_i].lo),
    .rdata (bus.mem_rdata),
    .data  (aligned)
  );

`ifdef MEM_RESP_ALIGN_BYPASS_EN
  // Response lands on the head entry: present it this cycle.
  assign byp = rsp_hit && (rsp_q == rd_q);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    bus.wb_valid = 1'b0;
    bus.wb_data  = '0;
    bus.wb_tag   = '0;
    bus.st_done  = 1'b0;
    pop          = 1'b0;
    if (head_done) begin
      if (ent_q[rd_i].fn == memfnt::st) begin
        bus.st_done = 1'b1;
        pop         = 1'b1;
      end else begin
        bus.wb_valid = 1'b1;
        bus.wb_data  = dat_q[rd_i];
        bus.wb_tag   = ent_q[rd_i].tag;
        pop          = bus.wb_ready;
      end
    end else if (byp) begin
      if (ent_q[rd_i].fn == memfnt::st) begin
        bus.st_done = 1'b1;
        pop         = 1'b1;
      end else begin
        bus.wb_valid = 1'b1;
        bus.wb_data  = aligned;
        bus.wb_tag   = ent_q[rd_i].tag;
        pop          = bus.wb_ready;
      end
    end
  end

  // A bypassed entry that retires immediately is never marked done.
  assign byp_pop = byp && pop;

  assign bus.req_ready = rdy;
  assign bus.err_unexp = err_q;

  // Entry payload needs no reset: it is only read once done/bypass says so.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[wr_i] <= '{fn:  bus.req_memfn, sz: bus.req_memsz,
                       ext: bus.req_ldext, lo: bus.req_addr_lo,
                       tag: bus.req_tag};
    end
    if (rsp_hit) dat_q[rsp_i] <= aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rsp_q  <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // push never targets rsp (rsp_hit needs rsp != wr), so no overlap
      if (push) begin
        done_q[wr_i] <= 1'b0;
        wr_q         <= wr_q + 1'b1;
      end
      if (rsp_hit) begin
        if (!byp_pop) done_q[rsp_i] <= 1'b1;
        rsp_q <= rsp_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (bus.mem_resp && !pending) err_q <= 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_mem_resp_align.sv
// Directed bench for mem_resp_align: a request model turns each response
// into an expected writeback/store-retire item; a negedge monitor pops
// and compares them as the DUT retires.
module tb_mem_resp_align;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_resp_align_if #(.TAG_W(6)) bus ();

  mem_resp_align #(.DEPTH(4), .TAG_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef MEM_RESP_ALIGN_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    memfnt::mem_func_t fn;
    memszt::mem_size_t sz;
    ldextt::load_ext_t ext;
    logic [1:0]        lo;
    logic [5:0]        tag;
  } req_t;

  typedef struct {
    bit          is_st;
    logic [31:0] data;
    logic [5:0]  tag;
  } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input req_t r, input logic [31:0] d);
    logic [31:0] sh;
    case (r.sz)
      memszt::b: begin
        sh = d >> (8 * int'(r.lo));
        return (r.ext == ldextt::s && sh[7]) ? (sh | 32'hFFFF_FF00) & 32'hFFFF_FFFF
                                             : (sh & 32'h0000_00FF);
      end
      memszt::h: begin
        sh = r.lo[1] ? (d >> 16) : d;
        return (r.ext == ldextt::s && sh[15]) ? (sh | 32'hFFFF_0000)
                                              : (sh & 32'h0000_FFFF);
      end
      default: return d;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input memfnt::mem_func_t fn, input memszt::mem_size_t sz,
                       input ldextt::load_ext_t ext, input logic [1:0] lo,
                       input logic [5:0] tag);
    req_t r;
    bus.req_valid   = 1'b1;
    bus.req_memfn   = fn;
    bus.req_memsz   = sz;
    bus.req_ldext   = ext;
    bus.req_addr_lo = lo;
    bus.req_tag     = tag;
    if (fn != memfnt::nm) begin
      r = '{fn: fn, sz: sz, ext: ext, lo: lo, tag: tag};
      req_q.push_back(r);
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  // drive one response pulse and record what it should produce
  task automatic resp_set(input logic [31:0] d);
    req_t r;
    exp_t e;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = d;
    if (req_q.size() > 0) begin
      r = req_q.pop_front();
      e = '{is_st: (r.fn == memfnt::st), data: model(r, d), tag: r.tag};
      exp_q.push_back(e);
    end
  endtask

  task automatic resp(input logic [31:0] d);
    resp_set(d);
    step();
    bus.mem_resp = 1'b0;
  endtask

  // retire monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((bus.wb_valid && bus.wb_ready) || bus.st_done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_retire", {bus.wb_valid, bus.st_done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("retire_kind", {31'd0, bus.st_done}, {31'd0, e.is_st});
        if (!e.is_st) begin
          chk("wb_data", bus.wb_data, e.data);
          chk("wb_tag", {26'd0, bus.wb_tag}, {26'd0, e.tag});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_memfn   = memfnt::nm;
    bus.req_memsz   = memszt::w;
    bus.req_ldext   = ldextt::z;
    bus.req_addr_lo = 2'd0;
    bus.req_tag     = '0;
    bus.mem_resp    = 1'b0;
    bus.mem_rdata   = '0;
    bus.wb_ready    = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_tag", {26'd0, bus.wb_tag}, 32'd0);
    chk("rst_st_done", {31'd0, bus.st_done}, 32'd0);
    chk("rst_err", {31'd0, bus.err_unexp}, 32'd0);
    rst_n = 1'b1;
    step();

    // lb addr_lo=3 -> sign-extended 0x80, one cycle after the response
    issue(memfnt::ld, memszt::b, ldextt::s, 2'd3, 6'd1);
    resp_set(32'h80FF_1234);
    @(negedge clk);
    chk("lb_lat_n", {31'd0, bus.wb_valid}, {31'd0, BYP});
    step();
    bus.mem_resp = 1'b0;
    @(negedge clk);
    if (!BYP) chk("lb_lat_n1", {31'd0, bus.wb_valid}, 32'd1);
    step();

    // lhu upper half, lh lower half
    issue(memfnt::ld, memszt::h, ldextt::z, 2'd2, 6'd2);
    issue(memfnt::ld, memszt::h, ldextt::s, 2'd0, 6'd3);
    resp(32'h8001_ABCD);
    resp(32'h8001_ABCD);
    step();

    // sw then lw: one st_done, one writeback
    issue(memfnt::st, memszt::w, ldextt::z, 2'd0, 6'd4);
    issue(memfnt::ld, memszt::w, ldextt::s, 2'd1, 6'd5);
    resp(32'hDEAD_BEEF);
    resp(32'h1234_5678);
    step();
    step();

    // fill the tracker, then stall writeback through all responses
    bus.wb_ready = 1'b0;
    issue(memfnt::ld, memszt::w, ldextt::z, 2'd0, 6'd10);
    issue(memfnt::ld, memszt::b, ldextt::z, 2'd1, 6'd11);
    issue(memfnt::ld, memszt::h, ldextt::s, 2'd2, 6'd12);
    issue(memfnt::ld, memszt::b, ldextt::s, 2'd0, 6'd13);
    @(negedge clk);
    chk("full_req_ready", {31'd0, bus.req_ready}, 32'd0);
    resp(32'hCAFE_0001);
    @(negedge clk);
    chk("stall_valid0", {31'd0, bus.wb_valid}, 32'd1);
    chk("stall_data0", bus.wb_data, exp_q[0].data);
    resp(32'h0000_7F00);
    resp(32'h9000_0000);
    resp(32'h0000_00F1);
    @(negedge clk);
    chk("stall_valid3", {31'd0, bus.wb_valid}, 32'd1);
    chk("stall_data3", bus.wb_data, exp_q[0].data);
    chk("stall_tag3", {26'd0, bus.wb_tag}, 32'd10);
    step();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("drain_valid%0d", i), {31'd0, bus.wb_valid}, 32'd1);
      step();
    end
    @(negedge clk);
    chk("drained_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("drained_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("drained_exp_q", exp_q.size(), 32'd0);

    // unexpected response on an empty tracker
    resp(32'h5555_5555);
    @(negedge clk);
    chk("err_set", {31'd0, bus.err_unexp}, 32'd1);
    chk("err_no_wb", {31'd0, bus.wb_valid}, 32'd0);
    step();
    step();
    @(negedge clk);
    chk("err_sticky", {31'd0, bus.err_unexp}, 32'd1);

    // nm takes no slot: ready stays up after 3 loads, drops after 4
    bus.wb_ready = 1'b0;
    issue(memfnt::nm, memszt::w, ldextt::z, 2'd0, 6'd20);
    issue(memfnt::ld, memszt::w, ldextt::z, 2'd0, 6'd21);
    issue(memfnt::ld, memszt::w, ldextt::z, 2'd0, 6'd22);
    issue(memfnt::ld, memszt::w, ldextt::z, 2'd0, 6'd23);
    @(negedge clk);
    chk("nm_ready3", {31'd0, bus.req_ready}, 32'd1);
    issue(memfnt::ld, memszt::w, ldextt::z, 2'd0, 6'd24);
    @(negedge clk);
    chk("nm_ready4", {31'd0, bus.req_ready}, 32'd0);
    resp(32'h1111_1111);
    resp(32'h2222_2222);

    // async reset mid-drain with two still pending
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("arst_wb_data", bus.wb_data, 32'd0);
    chk("arst_wb_tag", {26'd0, bus.wb_tag}, 32'd0);
    chk("arst_st_done", {31'd0, bus.st_done}, 32'd0);
    chk("arst_err", {31'd0, bus.err_unexp}, 32'd0);
    chk("arst_ready", {31'd0, bus.req_ready}, 32'd1);
    req_q.delete();
    exp_q.delete();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // fresh lbu from empty
    bus.wb_ready = 1'b1;
    issue(memfnt::ld, memszt::b, ldextt::z, 2'd1, 6'd7);
    resp(32'h0000_AB00);
    step();
    step();
    @(negedge clk);
    chk("post_rst_exp_q", exp_q.size(), 32'd0);
    chk("post_rst_req_q", req_q.size(), 32'd0);
    chk("post_rst_err", {31'd0, bus.err_unexp}, 32'd0);
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
